bip_program_loader: RTL
=======================

Name: bip_program_loader

Overview:
- Producer end of the BIP-2 instruction stream: packs opcode/operand pairs into 16-bit instruction words and writes them sequentially into program memory.
- Output words are the format the control decoder consumes: opcode in [15:11], operand in [10:0].
- Holds the CPU in reset while a program is loading, appends an HLT terminator, then releases the CPU.
- Sits between a host/test source and the program-memory write port, beside the BIP-2 core.

Parameters:
- OPCODE_WIDTH, 5, opcode field width.
- OPERAND_WIDTH, 11, operand field width.
- ADDR_WIDTH, 11, program memory address width.
- PROG_DEPTH, 2048, number of program memory words. Must satisfy PROG_DEPTH <= 2**ADDR_WIDTH.
- MAX_OPCODE, 5'b01110, highest legal opcode (JMP).

Ports:
- clock_i  in  1  single clock; all logic rising-edge.
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  1-cycle pulse that begins a load session.
- valid_i  in  1  source has a word on opcode_i/operand_i.
- last_i  in  1  qualifies the final word of the program (sampled with valid_i).
- opcode_i  in  OPCODE_WIDTH  instruction opcode.
- operand_i  in  OPERAND_WIDTH  instruction operand.
- ready_o  out  1  loader accepts a word this cycle.
- wr_en_o  out  1  program memory write strobe.
- wr_addr_o  out  ADDR_WIDTH  program memory write address.
- wr_data_o  out  OPCODE_WIDTH+OPERAND_WIDTH  packed instruction word.
- cpu_hold_o  out  1  drives the CPU/PC reset; high = CPU held.
- done_o  out  1  load complete and CPU released.
- err_o  out  1  sticky; set by an illegal opcode or truncation.
- count_o  out  ADDR_WIDTH  user words written in the current session.

Behaviour:
- Reset (async, immediate):
  - State IDLE.
  - ready_o=0, wr_en_o=0, wr_addr_o=0, wr_data_o=0, done_o=0, err_o=0, count_o=0.
  - cpu_hold_o=1.
  - Program memory contents are not touched.
- All outputs are registered.
- States: IDLE, LOAD, FINISH, DONE.
- IDLE:
  - cpu_hold_o=1.
  - start_i -> LOAD next cycle; count and err are cleared; ready_o=1 from the first LOAD cycle.
- LOAD, accept rule:
  - A word is accepted on a cycle with valid_i && ready_o.
  - Source must hold its data stable until accepted.
  - valid_i is ignored when ready_o=0.
- LOAD, legal word (opcode_i <= MAX_OPCODE):
  - Next cycle: wr_en_o=1, wr_addr_o=count, wr_data_o={opcode_i, operand_i}; count increments.
  - Write latency is exactly 1 cycle after acceptance.
  - Back-to-back accepts give a write every cycle.
- LOAD, illegal word (opcode_i > MAX_OPCODE):
  - Word is dropped: no write, count unchanged.
  - err_o is set and stays set.
  - The session continues.
- Transition LOAD -> FINISH occurs when:
  - last_i is high on an accepted beat (legal or illegal), or
  - an accepted legal non-last word makes count reach PROG_DEPTH-1. This is truncation: err_o is set.
- ready_o falls in the same cycle the FINISH transition is registered; no further beat is accepted.
- Address PROG_DEPTH-1 is reserved for the terminator, so user words occupy at most PROG_DEPTH-1 slots.
- FINISH (single cycle):
  - wr_en_o=1, wr_addr_o=count, wr_data_o=0 (HLT with operand 0).
  - The terminator is always written, even if the last user word was HLT. count_o excludes it.
  - -> DONE.
- DONE:
  - cpu_hold_o=0 and done_o=1 from the cycle after the FINISH write.
  - count_o and err_o are held.
  - start_i -> LOAD: cpu_hold_o=1 and done_o=0 next cycle; count and err are cleared.
- start_i is ignored in LOAD and FINISH.
- Empty program (last_i on the first beat with an illegal opcode): only HLT is written at address 0; count_o=0; err_o=1.
- Reset mid-LOAD aborts the session with the outputs listed under Reset; partially written memory stays; the CPU remains held.
- wr_en_o is never high for two consecutive cycles at the same address.

Test Plan:
- Reset, start_i, then 3 beats (LDI 5, ADD 0x010, STO 0x020 with last_i):
  - Writes 0x1805@0, 0x2010@1, 0x0820@2, then 0x0000@3.
  - count_o=3; done_o=1 and cpu_hold_o=0 one cycle after the HLT write; err_o=0.
- Illegal opcode 5'b11111 sent mid-stream between two legal words:
  - No write for the illegal word; legal words land at consecutive addresses 0 and 1.
  - err_o=1 from the cycle after acceptance; the load completes normally.
- PROG_DEPTH=8, stream 10 legal words without last_i:
  - Addresses 0-6 written; ready_o low after the 7th accept; HLT written at address 7.
  - count_o=7, err_o=1, done_o=1.
- valid_i toggling with gaps, and valid_i held high while ready_o=0 in IDLE/FINISH:
  - Only handshaken beats write, each exactly 1 cycle after acceptance.
  - No write from the ignored beats.
- Assert reset_i during LOAD after 2 writes:
  - Outputs return to reset values asynchronously; cpu_hold_o stays 1.
  - A following start_i restarts writing at address 0.
- Reload: start_i while in DONE:
  - cpu_hold_o=1 and done_o=0 next cycle; count_o=0; err_o cleared.
  - A new 1-word program writes to address 0 and its HLT to address 1.

Source files
------------

// File: rtl/bip_program_loader.sv
// bip_program_loader: packs opcode/operand pairs into BIP-2 instruction words,
// writes them to program memory from address 0, appends an HLT word and
// then releases the CPU.
//
// Ports:
//   clock_i, reset_i              clock, asynchronous active-high reset
//   start_i                       pulse that begins a load session
//   valid_i, last_i               source handshake and end-of-program flag
//   opcode_i, operand_i           instruction fields from the source
//   ready_o                       loader accepts a word this cycle
//   wr_en_o, wr_addr_o, wr_data_o program memory write port
//   cpu_hold_o                    CPU held in reset while high
//   done_o                        load complete, CPU released
//   err_o                         sticky illegal-opcode / truncation flag
//   count_o                       user words written in this session
module bip_program_loader #(
   parameter int OPCODE_WIDTH  = 5,
   parameter int OPERAND_WIDTH = 11,
   parameter int ADDR_WIDTH    = 11,
   parameter int PROG_DEPTH    = 2048,
   parameter logic [OPCODE_WIDTH-1:0] MAX_OPCODE = 5'b01110
) (
   input  logic                                  clock_i,
   input  logic                                  reset_i,
   input  logic                                  start_i,
   input  logic                                  valid_i,
   input  logic                                  last_i,
   input  logic [OPCODE_WIDTH-1:0]               opcode_i,
   input  logic [OPERAND_WIDTH-1:0]              operand_i,
   output logic                                  ready_o,
   output logic                                  wr_en_o,
   output logic [ADDR_WIDTH-1:0]                 wr_addr_o,
   output logic [OPCODE_WIDTH+OPERAND_WIDTH-1:0] wr_data_o,
   output logic                                  cpu_hold_o,
   output logic                                  done_o,
   output logic                                  err_o,
   output logic [ADDR_WIDTH-1:0]                 count_o
);

   localparam int DW = OPCODE_WIDTH + OPERAND_WIDTH;

   // The top address is reserved for the HLT terminator, so the stream is
   // cut once a user word lands at PROG_DEPTH-2.
   localparam logic [ADDR_WIDTH-1:0] LAST_USER = ADDR_WIDTH'(PROG_DEPTH - 2);
   localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_FINISH,
      S_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic                    ready_q, ready_d;
   logic                    wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
   logic [DW-1:0]           wr_data_q, wr_data_d;
   logic                    hold_q, hold_d;
   logic                    done_q, done_d;
   logic                    err_q, err_d;
   logic [ADDR_WIDTH-1:0]   count_q, count_d;

   logic accept;
   logic legal;

   assign accept = valid_i && ready_q;
   assign legal  = (opcode_i <= MAX_OPCODE);

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= S_IDLE;
         ready_q   <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         hold_q    <= 1'b1;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         ready_q   <= ready_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         hold_q    <= hold_d;
         done_q    <= done_d;
         err_q     <= err_d;
         count_q   <= count_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ready_d   = ready_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      hold_d    = hold_q;
      done_d    = done_q;
      err_d     = err_q;
      count_d   = count_q;

      unique case (state_q)
         S_IDLE: begin
            hold_d = 1'b1;
            if (start_i) begin
               state_d = S_LOAD;
               ready_d = 1'b1;
               count_d = '0;
               err_d   = 1'b0;
            end
         end

         S_LOAD: begin
            if (accept) begin
               if (legal) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = count_q;
                  wr_data_d = {opcode_i, operand_i};
                  count_d   = count_q + ONE;
                  if (!last_i && count_q == LAST_USER) begin
                     err_d   = 1'b1;
                     state_d = S_FINISH;
                     ready_d = 1'b0;
                  end
               end else begin
                  err_d = 1'b1;
               end
               if (last_i) begin
                  state_d = S_FINISH;
                  ready_d = 1'b0;
               end
            end
         end

         S_FINISH: begin
            // HLT terminator: opcode 0, operand 0.
            wr_en_d   = 1'b1;
            wr_addr_d = count_q;
            wr_data_d = '0;
            state_d   = S_DONE;
         end

         S_DONE: begin
            hold_d = 1'b0;
            done_d = 1'b1;
            if (start_i) begin
               state_d = S_LOAD;
               ready_d = 1'b1;
               hold_d  = 1'b1;
               done_d  = 1'b0;
               count_d = '0;
               err_d   = 1'b0;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign ready_o    = ready_q;
   assign wr_en_o    = wr_en_q;
   assign wr_addr_o  = wr_addr_q;
   assign wr_data_o  = wr_data_q;
   assign cpu_hold_o = hold_q;
   assign done_o     = done_q;
   assign err_o      = err_q;
   assign count_o    = count_q;

endmodule
